// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants and helpers for the pipeline stall/flush controller.
// Stage indices follow pipeline order, so stage 0 is the PC register.
package pipeline_ctrl_pkg;

    localparam int STG_PC = 0;
    localparam int STG_IF = 1;
    localparam int STG_ID = 2;
    localparam int STG_EX = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB = 5;

    localparam int DEF_STAGES = 6;
    localparam int DEF_CNT_W = 8;
    localparam int DEF_WDOG_LIMIT = 255;

    // Widest pipeline the mask helper supports; callers truncate to STAGES.
    localparam int MAX_STAGES = 32;

    // A stall at some level freezes that stage and every stage upstream of it.
    function automatic logic [MAX_STAGES-1:0] therm_mask(input int unsigned level);
        logic [MAX_STAGES-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_STAGES; i++) begin
            if (i <= level) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_timer.sv
// Timed multi-cycle stall: loads a length and a stage, then counts down.
// The acceptance cycle is covered combinationally by the parent, so only len-1 cycles remain.
module stall_timer
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int STG_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic [CNT_W-1:0] len_i,
    input  logic [STG_W-1:0] stage_i,
    output logic             busy_o,
    output logic [STG_W-1:0] stage_o
);

    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [STG_W-1:0] stage_q, stage_d;

    always_comb begin
        remaining_d = remaining_q;
        stage_d     = stage_q;
        if (clear_i) begin
            remaining_d = '0;
        end else if (load_i) begin
            remaining_d = len_i - CNT_W'(1);
            stage_d     = stage_i;
        end else if (remaining_q != '0) begin
            remaining_d = remaining_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining_q <= '0;
            stage_q     <= '0;
        end else begin
            remaining_q <= remaining_d;
            stage_q     <= stage_d;
        end
    end

    assign busy_o  = (remaining_q != '0);
    assign stage_o = stage_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: merges stall sources into a per-stage freeze mask,
// applies flush priority, and keeps a stalled-cycle counter plus a sticky watchdog.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int STAGES = DEF_STAGES,
    parameter int CNT_W = DEF_CNT_W,
    parameter int WDOG_LIMIT = DEF_WDOG_LIMIT,
    localparam int STG_W = $clog2(STAGES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [STAGES-1:0] stall_req,
    input  logic              timed_req,
    input  logic [STG_W-1:0]  timed_stage,
    input  logic [CNT_W-1:0]  timed_len,
    input  logic              flush_req,
    input  logic [31:0]       flush_pc,
    output logic [STAGES-1:0] stall,
    output logic              flush,
    output logic [31:0]       new_pc,
    output logic              busy,
    output logic [31:0]       stall_cnt,
    output logic              wdog_err
);

    logic             timer_busy;
    logic [STG_W-1:0] timer_stage;
    logic [STG_W-1:0] accept_stage;
    logic             accept;

    int unsigned       level;
    logic              stall_any;
    logic [STAGES-1:0] stall_mask;
    logic              stalled;

    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] run_q, run_d;
    logic        wdog_err_q, wdog_err_d;

    // Stage 0 cannot request a stall on its own behalf.
    logic unused_req0;
    assign unused_req0 = stall_req[0];

    assign accept = timed_req && !timer_busy && (timed_len != '0) && !flush_req;

    // Stage indices beyond the pipeline depth freeze the whole pipeline.
    assign accept_stage = (32'(timed_stage) > 32'(STAGES - 1)) ? STG_W'(STAGES - 1) : timed_stage;

    stall_timer #(
        .CNT_W(CNT_W),
        .STG_W(STG_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load_i (accept),
        .clear_i(flush_req),
        .len_i  (timed_len),
        .stage_i(accept_stage),
        .busy_o (timer_busy),
        .stage_o(timer_stage)
    );

    always_comb begin
        level     = 0;
        stall_any = 1'b0;
        for (int unsigned k = 1; k < STAGES; k++) begin
            if (stall_req[k]) begin
                level     = k;
                stall_any = 1'b1;
            end
        end
        if (timer_busy) begin
            stall_any = 1'b1;
            if (32'(timer_stage) > level) begin
                level = 32'(timer_stage);
            end
        end
        if (accept) begin
            stall_any = 1'b1;
            if (32'(accept_stage) > level) begin
                level = 32'(accept_stage);
            end
        end
        stall_mask = stall_any ? STAGES'(therm_mask(level)) : '0;
    end

    assign stall   = (reset || flush_req) ? '0 : stall_mask;
    assign flush   = flush_req && !reset;
    assign new_pc  = flush ? flush_pc : 32'h0;
    assign stalled = (stall != '0);

    // The run counter saturates so a stall that never ends cannot wrap it back under the limit.
    always_comb begin
        stall_cnt_d = stall_cnt_q + (stalled ? 32'd1 : 32'd0);
        run_d       = run_q;
        wdog_err_d  = wdog_err_q;
        if (WDOG_LIMIT != 0) begin
            if (!stalled) begin
                run_d = '0;
            end else if (run_q < 32'(WDOG_LIMIT)) begin
                run_d = run_q + 32'd1;
            end
            if (run_d == 32'(WDOG_LIMIT)) begin
                wdog_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            run_q       <= '0;
            wdog_err_q  <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            run_q       <= run_d;
            wdog_err_q  <= wdog_err_d;
        end
    end

    assign busy      = timer_busy;
    assign stall_cnt = stall_cnt_q;
    assign wdog_err  = wdog_err_q;

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Parametrised pipeline stall/flush controller for the OpenMIPS-style core, sitting beside the stage registers and driving their per-stage freeze and flush inputs. It combines same-cycle stall requests from any stage with:
- a timed multi-cycle stall (e.g. multi-cycle divide, memory wait);
- a priority flush with redirect PC;
- a stalled-cycle performance counter;
- a sticky stall watchdog.

Stage index convention: 0=pc, 1=if, 2=id, 3=ex, 4=mem, 5=wb. A stall from stage k freezes stages 0..k.

## Interface
Parameters:
- STAGES, 6, number of pipeline stages (min 2).
- CNT_W, 8, width of timed-stall length.
- WDOG_LIMIT, 255, consecutive stalled cycles that trip the watchdog; 0 disables it.
- STG_W, derived localparam = $clog2(STAGES), stage-index width.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall_req  in  STAGES  bit k = stage k requests a stall this cycle; bit 0 ignored.
- timed_req  in  1  request a timed stall (single-cycle strobe).
- timed_stage  in  STG_W  deepest stage frozen by the timed stall.
- timed_len  in  CNT_W  total stall cycles; 0 = request ignored.
- flush_req  in  1  flush the pipeline this cycle.
- flush_pc  in  32  redirect target for the flush.
- stall  out  STAGES  per-stage freeze; bit k=1 holds stage k.
- flush  out  1  flush strobe to all stage registers.
- new_pc  out  32  redirect PC, valid when flush=1, else 0.
- busy  out  1  timed stall in progress (timer holding).
- stall_cnt  out  32  total cycles with stall≠0, wraps.
- wdog_err  out  1  sticky watchdog error.

## Operation
- Stall level L = max index k with stall_req[k]=1, including the timer's latched stage while busy, and timed_stage in a timed_req acceptance cycle. stall = bits 0..L set. No source active → stall=0.
- Timed stall accept:
  - condition: timed_req=1, busy=0, timed_len≠0, flush_req=0;
  - stall includes timed_stage in the acceptance cycle (combinational);
  - at the edge, the timer loads remaining=timed_len−1 and latches the stage;
  - busy=1 while remaining≠0; stall held; remaining decrements each edge.
- timed_req with busy=1 is ignored (no queueing). timed_len=1 gives exactly one stalled cycle and busy never rises.
- Flush has priority over everything:
  - flush_req=1 → same cycle: flush=1, new_pc=flush_pc, stall=0;
  - timer cleared at the next edge; coincident timed_req dropped.
- stall_cnt: +1 each edge where stall≠0; wraps 2^32−1→0.
- Watchdog:
  - run counter increments on each stalled edge and clears on a non-stalled edge;
  - saturates at WDOG_LIMIT;
  - on reaching WDOG_LIMIT, wdog_err sets and stays set until reset.
- Reset, including mid-timer: timer, busy, stall_cnt, run counter and wdog_err all cleared. stall=0, flush=0, new_pc=0 while reset is high.

## Timing
- stall, flush, new_pc: combinational from inputs and timer state, zero latency.
- busy, stall_cnt, wdog_err: registered, update one edge after the causing cycle.
- Timed stall spans exactly timed_len consecutive cycles, starting in the acceptance cycle.
- A flush mid-timer terminates the stall; stall=0 from the flush cycle on, unless a stall_req is present after the flush cycle.
- Simultaneous stall_req and active timer: deeper stage wins. The timer keeps counting during external stalls.

## Structure
- Package pipeline_ctrl_pkg:
  - stage index constants STG_PC..STG_WB;
  - default STAGES/CNT_W/WDOG_LIMIT;
  - function building the thermometer stall mask from a level.
- Sub-module stall_timer holds the load/decrement/busy counter and latched stage.
- Top level holds level merge, flush priority, perf counter and watchdog.

## Test plan
- Reset low, stall_req=6'b000100 → stall=6'b000111. stall_req=6'b001100 → stall=6'b001111. stall_req=0 → stall=0.
- timed_req, timed_stage=3, timed_len=4 → stall=6'b001111 for exactly 4 cycles; busy high cycles 2–4. Second timed_req during busy is ignored.
- Timer busy with stage 3, flush_req with flush_pc=32'h0000_0040 → same cycle flush=1, new_pc=32'h40, stall=0; busy=0 next cycle.
- WDOG_LIMIT=5, stall_req[2] held 5 cycles → wdog_err=1 after the 5th edge and stays high after the stall drops. A 4-cycle stall never trips it.
- 10 stalled cycles → stall_cnt=10. Reset asserted mid-timer (remaining=3) → busy, stall_cnt, wdog_err=0 immediately, without waiting for clk.
- STAGES=4 build: stall_req=4'b1000 → stall=4'b1111. timed_len=0 → no stall, busy stays 0.
